pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 39 +++
 rtl/pipe_ctrl_if.sv | 23 ++
 rtl/pipe_ctrl_stall_cnt.sv | 51 +++++
 rtl/pipe_ctrl.sv | 68 ++++++
 tb/tb_pipe_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared pipeline-control types, stage indices and stall encodings
package pipe_ctrl_pkg;

    localparam int REG_W = 32;
    typedef logic [REG_W-1:0] reg_bus_t;
    localparam reg_bus_t ZERO_WORD = '0;

    localparam int STALL_W = 6;
    typedef logic [STALL_W-1:0] stall_t;

    typedef enum int {
        STAGE_PC     = 0,
        STAGE_IF_ID  = 1,
        STAGE_ID_EX  = 2,
        STAGE_EX_MEM = 3,
        STAGE_MEM_WB = 4,
        STAGE_WB     = 5
    } stage_e;

    // A stall freezes the requesting stage and every stage upstream of it.
    function automatic stall_t hold_through(input stage_e last);
        stall_t m;
        m = '0;
        for (int i = 0; i < STALL_W; i++) begin
            if (i <= int'(last)) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam stall_t STALL_NONE = '0;
    localparam stall_t STALL_ID   = hold_through(STAGE_ID_EX);
    localparam stall_t STALL_EX   = hold_through(STAGE_EX_MEM);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - hazard request / stall-flush response bundle between pipeline and controller
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic     stallreq_id;
    logic     stallreq_ex;
    logic     flush_req;
    reg_bus_t flush_pc;
    stall_t   stall;
    logic     flush;
    reg_bus_t new_pc;

    modport master (
        output stallreq_id, stallreq_ex, flush_req, flush_pc,
        input  stall, flush, new_pc
    );

    modport slave (
        input  stallreq_id, stallreq_ex, flush_req, flush_pc,
        output stall, flush, new_pc
    );

endinterface

// File: rtl/pipe_ctrl_stall_cnt.sv
// rtl/pipe_ctrl_stall_cnt.sv - saturating consecutive-stall counter with optional watchdog (PIPE_CTRL_WDOG_EN)
module pipe_ctrl_stall_cnt #(
    parameter int CNT_W      = 8,
    parameter int WDOG_LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_active,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             wdog_timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (WDOG_LIMIT < 1 || 64'(WDOG_LIMIT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_limit
        $error("pipe_ctrl_stall_cnt: WDOG_LIMIT out of range for CNT_W");
    end

    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = stall_cnt;
        if (!stall_active)
            cnt_d = '0;
        else if (stall_cnt != CNT_MAX)
            cnt_d = stall_cnt + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else
            stall_cnt <= cnt_d;
    end

`ifdef PIPE_CTRL_WDOG_EN
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WDOG_LIMIT);

    // Sticky: only a reset clears a tripped watchdog.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wdog_timeout <= 1'b0;
        else if (stall_active && cnt_d == LIMIT)
            wdog_timeout <= 1'b1;
    end
`else
    assign wdog_timeout = 1'b0;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller; watchdog enabled by PIPE_CTRL_WDOG_EN
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int WDOG_LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    pipe_ctrl_if.slave       pif,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             wdog_timeout
);

    state_e   state_q, state_d;
    reg_bus_t new_pc_q;
    stall_t   stall_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    // A request arriving in FLUSH extends it, so back-to-back redirects are never lost.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (pif.flush_req) state_d = ST_FLUSH;
            ST_FLUSH: state_d = pif.flush_req ? ST_FLUSH : ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            new_pc_q <= ZERO_WORD;
        else if (pif.flush_req)
            new_pc_q <= pif.flush_pc;
    end

    always_comb begin
        stall_d = STALL_NONE;
        if (!rst || pif.flush_req || state_q == ST_FLUSH)
            stall_d = STALL_NONE;
        else if (pif.stallreq_ex)
            stall_d = STALL_EX;
        else if (pif.stallreq_id)
            stall_d = STALL_ID;
    end

    assign pif.stall  = stall_d;
    assign pif.flush  = (state_q == ST_FLUSH);
    assign pif.new_pc = new_pc_q;

    pipe_ctrl_stall_cnt #(
        .CNT_W      (CNT_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_stall_cnt (
        .clk          (clk),
        .rst          (rst),
        .stall_active (stall_d != STALL_NONE),
        .stall_cnt    (stall_cnt),
        .wdog_timeout (wdog_timeout)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl (watchdog expectations follow PIPE_CTRL_WDOG_EN)
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    typedef struct {
        logic        flush;
        logic [31:0] new_pc;
        logic [7:0]  cnt;
        logic        wdog;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] stall_cnt;
    logic       wdog_timeout;
    int         tests;
    int         failed;
    bit         tripped;
    exp_t       sb[$];

    pipe_ctrl_if pif();

    pipe_ctrl #(.CNT_W(8), .WDOG_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .pif          (pif),
        .stall_cnt    (stall_cnt),
        .wdog_timeout (wdog_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic drive(input logic id, input logic ex, input logic fr, input logic [31:0] pc);
        pif.stallreq_id = id;
        pif.stallreq_ex = ex;
        pif.flush_req   = fr;
        pif.flush_pc    = pc;
    endtask

    task automatic step(input string tag, input logic id, input logic ex, input logic fr,
                        input logic [31:0] pc, input logic [5:0] e_stall, input logic e_flush,
                        input logic [31:0] e_pc, input logic [7:0] e_cnt);
        exp_t e;
        @(negedge clk);
        drive(id, ex, fr, pc);
        #1;
        tests++;
        if (pif.stall !== e_stall) begin
            failed++;
            $display("FAIL %s stall: got %b want %b", tag, pif.stall, e_stall);
        end
        if (WDOG_ON && e_cnt == 8'd4) tripped = 1'b1;
        e.flush = e_flush; e.new_pc = e_pc; e.cnt = e_cnt; e.wdog = tripped;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        tests++;
        if (pif.flush !== e.flush) begin
            failed++;
            $display("FAIL %s flush: got %b want %b", tag, pif.flush, e.flush);
        end
        tests++;
        if (pif.new_pc !== e.new_pc) begin
            failed++;
            $display("FAIL %s new_pc: got %h want %h", tag, pif.new_pc, e.new_pc);
        end
        tests++;
        if (stall_cnt !== e.cnt) begin
            failed++;
            $display("FAIL %s stall_cnt: got %0d want %0d", tag, stall_cnt, e.cnt);
        end
        tests++;
        if (wdog_timeout !== e.wdog) begin
            failed++;
            $display("FAIL %s wdog_timeout: got %b want %b", tag, wdog_timeout, e.wdog);
        end
    endtask

    task automatic check_cleared(input string tag);
        tests++;
        if (pif.stall !== 6'b0 || pif.flush !== 1'b0 || pif.new_pc !== 32'h0 ||
            stall_cnt !== 8'd0 || wdog_timeout !== 1'b0) begin
            failed++;
            $display("FAIL %s: got stall=%b flush=%b new_pc=%h cnt=%0d wdog=%b want all zero",
                     tag, pif.stall, pif.flush, pif.new_pc, stall_cnt, wdog_timeout);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tripped = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset_requests_high");
        drive(1'b1, 1'b1, 1'b1, 32'h1234);
        @(posedge clk);
        #1;
        check_cleared("reset_flush_req_high");
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        step("reset_release", 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0, 8'd0);
    endtask

    task automatic test_stall_ex();
        for (int i = 1; i <= 3; i++)
            step("stall_ex", 0, 1, 0, 32'h0, 6'b001111, 0, 32'h0, 8'(i));
        step("stall_ex_drop", 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0, 8'd0);
    endtask

    task automatic test_stall_both();
        step("stall_both", 1, 1, 0, 32'h0, 6'b001111, 0, 32'h0, 8'd1);
        step("stall_id", 1, 0, 0, 32'h0, 6'b000111, 0, 32'h0, 8'd2);
        step("stall_both_drop", 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0, 8'd0);
    endtask

    task automatic test_flush_pulse();
        step("flush_req", 1, 0, 1, 32'h20, 6'b000000, 1, 32'h20, 8'd0);
        step("flush_cycle", 1, 0, 0, 32'h0, 6'b000000, 0, 32'h20, 8'd0);
        step("after_flush", 1, 0, 0, 32'h0, 6'b000111, 0, 32'h20, 8'd1);
        step("flush_idle", 0, 0, 0, 32'h0, 6'b000000, 0, 32'h20, 8'd0);
    endtask

    task automatic test_back_to_back();
        step("b2b_first", 0, 1, 1, 32'h40, 6'b000000, 1, 32'h40, 8'd0);
        step("b2b_second", 0, 1, 1, 32'h80, 6'b000000, 1, 32'h80, 8'd0);
        step("b2b_done", 0, 0, 0, 32'h0, 6'b000000, 0, 32'h80, 8'd0);
    endtask

    task automatic test_wdog();
        for (int i = 1; i <= 10; i++)
            step("wdog_stall", 0, 1, 0, 32'h0, 6'b001111, 0, 32'h80, 8'(i));
        step("wdog_after", 0, 0, 0, 32'h0, 6'b000000, 0, 32'h80, 8'd0);
    endtask

    task automatic test_saturate();
        for (int i = 1; i <= 258; i++)
            step("saturate", 0, 1, 0, 32'h0, 6'b001111, 0, 32'h80, (i > 255) ? 8'd255 : 8'(i));
        step("saturate_drop", 0, 0, 0, 32'h0, 6'b000000, 0, 32'h80, 8'd0);
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 3; i++)
            step("pre_reset_stall", 0, 1, 0, 32'h0, 6'b001111, 0, 32'h80, 8'(i));
        #2;
        rst = 1'b0;
        #1;
        check_cleared("async_reset_mid_stall");
        @(negedge clk);
        rst = 1'b1;
        tripped = 1'b0;
        step("enter_flush", 0, 0, 1, 32'h100, 6'b000000, 1, 32'h100, 8'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        check_cleared("async_reset_mid_flush");
        @(negedge clk);
        rst = 1'b1;
        step("post_reset_run", 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0, 8'd0);
        step("post_reset_stall", 1, 0, 0, 32'h0, 6'b000111, 0, 32'h0, 8'd1);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_stall_ex();
        test_stall_both();
        test_flush_pulse();
        test_back_to_back();
        test_wdog();
        test_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
